led_scan_ctrl: RTL and testbench

Sequencing controller for the board's 8-LED, 3-to-8 one-cold indicator path. It generates the 3-bit LED select from a prescaled time base or from a debounced push-button step. It supports hold, up-scan, down-scan and bounce modes selected by two switches, and it decodes the select into the active-low LED vector. It sits between the board switches/key and the LED pins, replacing static switch-driven selection with timed scanning.

---
 rtl/led_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_led_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// LED scan controller: prescaled or key-stepped 3-bit LED select with hold,
// up, down and bounce modes, decoded to an active-low one-cold LED vector.
module led_scan_ctrl #(
  parameter int TICK_DIV   = 12_000_000,
  parameter int DEB_CYCLES = 240_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       key_n,
  output logic [2:0] sel,
  output logic [7:0] led,
  output logic       tick
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_t;

  typedef enum logic {
    BOUNCE_UP   = 1'b0,
    BOUNCE_DOWN = 1'b1
  } bounce_t;

  localparam int                CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam int                DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0]  DEB_MAX = DEB_W'(DEB_CYCLES - 1);

  mode_t            mode_s1;
  mode_t            mode_s2;
  logic             mode_chg;
  logic             enter_bounce;
  logic [CNT_W-1:0] presc;

  logic             key_s1;
  logic             key_s2;
  logic [1:0]       key_vld;
  logic             deb;
  logic [DEB_W-1:0] deb_cnt;
  logic             armed;
  logic             step_req;

  bounce_t          bstate;
  logic             step;

  // mode_s1 holds the value mode_s2 takes at the next edge, so a pending
  // change is visible one cycle early and the counter clears exactly as it lands.
  assign mode_chg     = (mode_s1 != mode_s2);
  assign enter_bounce = (mode_s1 == MODE_BOUNCE) && (mode_s2 != MODE_BOUNCE);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, whatever the block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_s1 <= MODE_HOLD;
      mode_s2 <= MODE_HOLD;
    end else begin
      mode_s1 <= mode_t'(mode);
      mode_s2 <= mode_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (mode_s2 == MODE_HOLD || mode_chg) begin
      presc <= '0;
    end else if (presc == CNT_MAX) begin
      presc <= '0;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  assign tick = (mode_s2 != MODE_HOLD) && !mode_chg && (presc == CNT_MAX);

  // Key path. armed blocks the first press after reset until a released level
  // has actually been seen, so a key held through reset cannot step.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      key_vld  <= 2'b00;
      deb      <= 1'b1;
      deb_cnt  <= '0;
      armed    <= 1'b0;
      step_req <= 1'b0;
    end else begin
      key_s1   <= key_n;
      key_s2   <= key_s1;
      key_vld  <= {key_vld[0], 1'b1};
      step_req <= 1'b0;
      if (key_vld[1] && key_s2 && deb) begin
        armed <= 1'b1;
      end
      if (key_s2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_MAX) begin
        deb      <= key_s2;
        deb_cnt  <= '0;
        step_req <= armed & ~key_s2;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  assign step = tick | step_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel    <= 3'd0;
      bstate <= BOUNCE_UP;
    end else begin
      if (enter_bounce) begin
        bstate <= (sel == 3'd7) ? BOUNCE_DOWN : BOUNCE_UP;
      end
      if (step) begin
        case (mode_s2)
          MODE_HOLD, MODE_UP: sel <= sel + 3'd1;
          MODE_DOWN:          sel <= sel - 3'd1;
          MODE_BOUNCE: begin
            // Endpoints turn around immediately so 0 and 7 are never repeated.
            case (bstate)
              BOUNCE_UP: begin
                if (sel == 3'd7) begin
                  sel    <= 3'd6;
                  bstate <= BOUNCE_DOWN;
                end else begin
                  sel <= sel + 3'd1;
                end
              end
              BOUNCE_DOWN: begin
                if (sel == 3'd0) begin
                  sel    <= 3'd1;
                  bstate <= BOUNCE_UP;
                end else begin
                  sel <= sel - 3'd1;
                end
              end
              default: sel <= sel;
            endcase
          end
          default: sel <= sel;
        endcase
      end
    end
  end

  assign led = ~(8'h80 >> sel);

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: constant vector table, directed corner sequences and
// a randomized run against an arithmetic reference model.
module tb_led_scan_ctrl;

  localparam int TD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       key_n;
  logic [2:0] sel;
  logic [7:0] led;
  logic       tick;

  led_scan_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
    .clk   (clk),
    .rst   (rst),
    .mode  (mode),
    .key_n (key_n),
    .sel   (sel),
    .led   (led),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] mode;
    logic       key_n;
    logic [2:0] sel;
    logic       tick;
    logic [7:0] led;
  } vec_t;

  vec_t tbl[25];
  int   bexp[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state (plain integers).
  int m_ms1, m_ms2, m_ks1, m_ks2, m_kvld, m_ph, m_deb, m_run;
  int m_armed, m_sreq, m_sel, m_bdir;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: dut=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int model_tick();
    return (m_ms2 != 0 && m_ms1 == m_ms2 && m_ph == TD - 1) ? 1 : 0;
  endfunction

  function automatic int model_led();
    logic [7:0] v;
    v = ~(8'h80 >> m_sel);
    return int'(v);
  endfunction

  task automatic model_edge(input int m, input int k, input int r);
    int tk, old_sel, nxt, nsreq, narmed;
    if (r != 0) begin
      m_ms1 = 0; m_ms2 = 0; m_ks1 = 1; m_ks2 = 1; m_kvld = 0; m_ph = 0;
      m_deb = 1; m_run = 0; m_armed = 0; m_sreq = 0; m_sel = 0; m_bdir = 1;
      return;
    end
    tk      = model_tick();
    old_sel = m_sel;
    if (tk != 0 || m_sreq != 0) begin
      case (m_ms2)
        2: m_sel = (m_sel + 7) % 8;
        3: begin
          nxt = m_sel + m_bdir;
          if (nxt > 7) begin
            nxt = 6; m_bdir = -1;
          end else if (nxt < 0) begin
            nxt = 1; m_bdir = 1;
          end
          m_sel = nxt;
        end
        default: m_sel = (m_sel + 1) % 8;
      endcase
    end
    if (m_ms1 == 3 && m_ms2 != 3) m_bdir = (old_sel == 7) ? -1 : 1;
    if (m_ms2 == 0 || m_ms1 != m_ms2) m_ph = 0;
    else m_ph = (m_ph + 1) % TD;
    narmed = m_armed;
    if (m_kvld >= 2 && m_ks2 == 1 && m_deb == 1) narmed = 1;
    nsreq = 0;
    if (m_ks2 == m_deb) begin
      m_run = 0;
    end else if (m_run + 1 >= DB) begin
      m_deb = m_ks2;
      m_run = 0;
      nsreq = (m_armed != 0 && m_ks2 == 0) ? 1 : 0;
    end else begin
      m_run++;
    end
    m_armed = narmed;
    m_sreq  = nsreq;
    m_ms2   = m_ms1;
    m_ms1   = m;
    m_ks2   = m_ks1;
    m_ks1   = k;
    if (m_kvld < 2) m_kvld++;
  endtask

  // Drive at the falling edge, clock once, return at the next falling edge.
  task automatic apply(input logic [1:0] m, input logic k, input logic r);
    mode  = m;
    key_n = k;
    rst   = r;
    @(posedge clk);
    model_edge(int'(m), int'(k), int'(r));
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, " sel"}, int'(sel), m_sel);
    check({tag, " led"}, int'(led), model_led());
    check({tag, " tick"}, int'(tick), model_tick());
  endtask

  task automatic run(input logic [1:0] m, input logic k, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      apply(m, k, 1'b0);
      check_model(tag);
    end
  endtask

  initial begin
    int got[$];
    int prev;
    int nticks;
    int mode_left;
    int key_left;
    logic [1:0] rm;
    logic rk;
    logic rr;

    rst = 1'b1; mode = 2'd0; key_n = 1'b1;

    // Reset into UP, two ticks, then DOWN through the 0 -> 7 wrap.
    tbl[0]  = '{1'b1, 2'd1, 1'b1, 3'd0, 1'b0, 8'h7F};
    tbl[1]  = '{1'b0, 2'd1, 1'b1, 3'd0, 1'b0, 8'h7F};
    tbl[2]  = '{1'b0, 2'd1, 1'b1, 3'd0, 1'b0, 8'h7F};
    tbl[3]  = '{1'b0, 2'd1, 1'b1, 3'd0, 1'b0, 8'h7F};
    tbl[4]  = '{1'b0, 2'd1, 1'b1, 3'd0, 1'b0, 8'h7F};
    tbl[5]  = '{1'b0, 2'd1, 1'b1, 3'd0, 1'b1, 8'h7F};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, 3'd1, 1'b0, 8'hBF};
    tbl[7]  = '{1'b0, 2'd1, 1'b1, 3'd1, 1'b0, 8'hBF};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 3'd1, 1'b0, 8'hBF};
    tbl[9]  = '{1'b0, 2'd1, 1'b1, 3'd1, 1'b1, 8'hBF};
    tbl[10] = '{1'b0, 2'd1, 1'b1, 3'd2, 1'b0, 8'hDF};
    tbl[11] = '{1'b0, 2'd2, 1'b1, 3'd2, 1'b0, 8'hDF};
    tbl[12] = '{1'b0, 2'd2, 1'b1, 3'd2, 1'b0, 8'hDF};
    tbl[13] = '{1'b0, 2'd2, 1'b1, 3'd2, 1'b0, 8'hDF};
    tbl[14] = '{1'b0, 2'd2, 1'b1, 3'd2, 1'b0, 8'hDF};
    tbl[15] = '{1'b0, 2'd2, 1'b1, 3'd2, 1'b1, 8'hDF};
    tbl[16] = '{1'b0, 2'd2, 1'b1, 3'd1, 1'b0, 8'hBF};
    tbl[17] = '{1'b0, 2'd2, 1'b1, 3'd1, 1'b0, 8'hBF};
    tbl[18] = '{1'b0, 2'd2, 1'b1, 3'd1, 1'b0, 8'hBF};
    tbl[19] = '{1'b0, 2'd2, 1'b1, 3'd1, 1'b1, 8'hBF};
    tbl[20] = '{1'b0, 2'd2, 1'b1, 3'd0, 1'b0, 8'h7F};
    tbl[21] = '{1'b0, 2'd2, 1'b1, 3'd0, 1'b0, 8'h7F};
    tbl[22] = '{1'b0, 2'd2, 1'b1, 3'd0, 1'b0, 8'h7F};
    tbl[23] = '{1'b0, 2'd2, 1'b1, 3'd0, 1'b1, 8'h7F};
    tbl[24] = '{1'b0, 2'd2, 1'b1, 3'd7, 1'b0, 8'hFE};

    @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      apply(tbl[i].mode, tbl[i].key_n, tbl[i].rst);
      check($sformatf("tbl[%0d] sel", i), int'(sel), int'(tbl[i].sel));
      check($sformatf("tbl[%0d] tick", i), int'(tick), int'(tbl[i].tick));
      check($sformatf("tbl[%0d] led", i), int'(led), int'(tbl[i].led));
    end

    // UP wrap: 9 single-cycle ticks in 40 cycles, sel ends at 9 mod 8.
    apply(2'd1, 1'b1, 1'b1);
    nticks = 0;
    for (int i = 0; i < 40; i++) begin
      apply(2'd1, 1'b1, 1'b0);
      check_model("up");
      if (tick) nticks++;
    end
    check("up tick count", nticks, 9);
    check("up wrap sel", int'(sel), 1);

    // BOUNCE from 0: 1..7,6..0,1 with no repeated endpoint.
    apply(2'd3, 1'b1, 1'b1);
    prev = 0;
    for (int c = 0; c < 200 && got.size() < 15; c++) begin
      apply(2'd3, 1'b1, 1'b0);
      check_model("bounce");
      if (int'(sel) != prev) begin
        got.push_back(int'(sel));
        prev = int'(sel);
      end
    end
    check("bounce step count", got.size(), 15);
    for (int j = 0; j < got.size() && j < 15; j++) check($sformatf("bounce seq[%0d]", j), got[j], bexp[j]);

    // Entering BOUNCE at sel=7 goes to 6.
    apply(2'd1, 1'b1, 1'b1);
    for (int c = 0; c < 100 && sel != 3'd7; c++) begin
      apply(2'd1, 1'b1, 1'b0);
      check_model("to7");
    end
    check("reach sel 7", int'(sel), 7);
    for (int c = 0; c < 40 && sel == 3'd7; c++) begin
      apply(2'd3, 1'b1, 1'b0);
      check_model("enter bounce");
    end
    check("bounce from 7", int'(sel), 6);

    // Debounce in HOLD: short glitch rejected, long press steps once, release does not.
    apply(2'd0, 1'b1, 1'b1);
    run(2'd0, 1'b1, 5, "deb idle");
    run(2'd0, 1'b0, 2, "deb glitch");
    run(2'd0, 1'b1, 10, "deb glitch");
    check("glitch no step", int'(sel), 0);
    run(2'd0, 1'b0, 10, "deb press");
    check("press one step", int'(sel), 1);
    run(2'd0, 1'b1, 12, "deb release");
    check("release no step", int'(sel), 1);

    // Key step_req lands on the same cycle as the second tick: one advance only.
    apply(2'd1, 1'b1, 1'b1);
    run(2'd1, 1'b1, 4, "coinc");
    run(2'd1, 1'b0, 6, "coinc");
    check("coincident single step", int'(sel), 2);
    run(2'd1, 1'b1, 8, "coinc release");

    // Key held low through reset: no step until released and pressed again.
    run(2'd0, 1'b0, 5, "held pre");
    apply(2'd0, 1'b0, 1'b1);
    check_model("held rst");
    run(2'd0, 1'b0, 15, "held");
    check("held through reset", int'(sel), 0);
    run(2'd0, 1'b1, 10, "held release");
    run(2'd0, 1'b0, 10, "held repress");
    check("fresh press steps", int'(sel), 1);

    // Randomized run against the model.
    mode_left = 0; key_left = 0; rm = 2'd0; rk = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (mode_left == 0) begin
        rm = 2'($urandom_range(0, 3));
        mode_left = int'($urandom_range(5, 60));
      end
      if (key_left == 0) begin
        rk = ~rk;
        key_left = int'($urandom_range(1, 12));
      end
      rr = ($urandom_range(0, 299) == 0);
      apply(rm, rk, rr);
      check_model("rand");
      mode_left--;
      key_left--;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
